hit_lane_merge: RTL
===================

Name: hit_lane_merge

Overview:
- Sits between the three-lane sample test stage (lanes A/B/C, R18) and the single-lane z-buffer/fragment consumer (R19).
- Each cycle it accepts up to three hit samples, compacts them in lane order A, B, C, and pushes them into a circular FIFO.
- It drains one sample per cycle through a valid/ready handshake.
- It stalls the upstream stage through halt_RnnnnL when fewer than three free entries remain.

Parameters:
- SIGFIG, 24, bits in position/depth/color words
- RADIX, 10, fraction bits in position
- AXIS, 3, axes per hit (x, y, z)
- COLORS, 3, color channels
- DEPTH, 8, FIFO entries; power of two, minimum 4
- DEPTH_L2, 3, log2(DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- hit_R18S  in  AXIS x SIGFIG signed  lane A hit position/depth
- color_R18U  in  COLORS x SIGFIG  lane A color
- hit_valid_R18H  in  1  lane A valid
- hit_R18S_B, color_R18U_B, hit_valid_R18H_B  in  as lane A  lane B
- hit_R18S_C, color_R18U_C, hit_valid_R18H_C  in  as lane A  lane C
- halt_RnnnnL  out  1  low = upstream must hold all lanes invalid
- hit_R19S  out  AXIS x SIGFIG signed  head sample position/depth
- color_R19U  out  COLORS x SIGFIG  head sample color
- hit_valid_R19H  out  1  head sample valid
- ready_R19H  in  1  downstream accepts head this cycle
- sample_cnt_RnnnnU  out  32  samples popped since reset
- overflow_R19H  out  1  sticky: a valid sample was dropped

Behaviour:
- Reset (async, rst=1):
  - rd_ptr, wr_ptr and count go to 0.
  - hit_valid_R19H=0, halt_RnnnnL=1, sample_cnt_RnnnnU=0, overflow_R19H=0.
  - hit_R19S and color_R19U read 0.
  - Storage array contents are not reset.
  - Reset asserted mid-transfer discards all buffered samples; no partial pop is counted.
- Push:
  - n_push = popcount of the three lane valids.
  - Valid lanes are written to wr_ptr, wr_ptr+1, wr_ptr+2 (mod DEPTH) in A, B, C order, skipping invalid lanes. Example: A and C valid → A at wr_ptr, C at wr_ptr+1.
  - wr_ptr advances by n_push, modulo DEPTH.
- Pop:
  - pop = hit_valid_R19H & ready_R19H.
  - rd_ptr advances by 1 modulo DEPTH; sample_cnt_RnnnnU increments by 1 and wraps at 2^32.
- Count update: count_next = count + n_push - pop. Width DEPTH_L2+1; range 0..DEPTH.
- Simultaneous push and pop:
  - Both take effect in the same cycle.
  - The pop frees its slot only after the edge; space for the push is judged against registered count.
- Output path:
  - hit_valid_R19H = (count != 0).
  - hit_R19S/color_R19U = entry at rd_ptr, combinational from registers.
  - Data is held stable while valid & !ready.
- Latency: a sample pushed into an empty FIFO at edge N is presented valid in the cycle after edge N (1 cycle).
- Order: strictly FIFO; within one cycle A precedes B precedes C.
- Halt: halt_RnnnnL = 0 iff count > DEPTH-3, decoded from the registered count only.
- Overflow:
  - Occurs if count + n_push > DEPTH; upstream ignored halt.
  - Lanes that do not fit are dropped in priority C, then B, then A.
  - Samples that fit are stored.
  - overflow_R19H sets and stays set until reset.
- Full with ready=0: count stays at DEPTH, halt_RnnnnL=0, head unchanged.
- Empty with ready=1: no pop; sample_cnt_RnnnnU unchanged.
- Bit-exact: samples pass through unmodified, with no fixed-point conversion.

Decomposition:
- Shared package raster_sample_pkg:
  - hit_sample_t: packed struct of AXIS signed SIGFIG position words plus COLORS unsigned SIGFIG color words.
  - Constants LANES=3 and HALT_SLACK=3.
- One sub-module, hit_lane_compact (combinational):
  - Inputs: three hit_sample_t plus valids.
  - Outputs: compacted slot[0..2], slot_valid, n_push.
- Top level holds the storage array, pointers, count, counters and halt/overflow logic.

Test Plan:
- Single sample: A valid once with hit x=0x000C00, y=0x001400, z=0x0ABCDE, ready=1 → hit_valid_R19H=1 the next cycle with identical data; sample_cnt_RnnnnU=1 a cycle later.
- Compaction: one cycle with A and C valid (A z=1, C z=3), ready=1 → output z=1 then z=3 on consecutive cycles; count goes 2,1,0.
- Backpressure/halt: ready=0, feed 3 valid lanes for 2 cycles → count=6, halt_RnnnnL=0 (6 > 5); raise ready → halt_RnnnnL=1 once count ≤ 5; 6 samples out in order.
- Wrap-around: DEPTH=8, stream 20 samples of one lane with ready toggling 1,0,1,0 → all 20 emerge in order with no overflow; pointers wrap twice.
- Overflow: count=7, ready=0, force all three lanes valid → A stored, B and C dropped, count=8, overflow_R19H=1 and stays set until rst.
- Async reset mid-stream: assert rst between edges while count=4 → hit_valid_R19H=0, halt_RnnnnL=1 and sample_cnt_RnnnnU=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/raster_sample_pkg.sv
// Shared types for the raster sample path between the sample test stage and the z-buffer.
// A hit carries signed fixed-point position/depth words and unsigned color words, passed through untouched.
package raster_sample_pkg;

    localparam int SIGFIG     = 24;
    localparam int AXIS       = 3;
    localparam int COLORS     = 3;
    localparam int LANES      = 3;
    localparam int HALT_SLACK = 3;

    typedef struct packed {
        logic signed [AXIS-1:0][SIGFIG-1:0] pos;
        logic        [COLORS-1:0][SIGFIG-1:0] color;
    } hit_sample_t;

endpackage

// File: rtl/hit_lane_compact.sv
// Packs the valid lanes of one cycle into consecutive slots, keeping lane order A, B, C.
// Purely combinational; slot[0] always holds the earliest valid lane.
module hit_lane_compact
    import raster_sample_pkg::*;
(
    input  hit_sample_t      lane_a,
    input  hit_sample_t      lane_b,
    input  hit_sample_t      lane_c,
    input  logic [LANES-1:0] lane_valid,
    output hit_sample_t      slot [LANES],
    output logic [LANES-1:0] slot_valid,
    output logic [1:0]       n_push
);

    hit_sample_t lanes [LANES];

    always_comb begin
        lanes[0]   = lane_a;
        lanes[1]   = lane_b;
        lanes[2]   = lane_c;
        n_push     = '0;
        slot_valid = '0;
        for (int k = 0; k < LANES; k++) begin
            slot[k] = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            if (lane_valid[i]) begin
                slot[n_push]       = lanes[i];
                slot_valid[n_push] = 1'b1;
                n_push             = n_push + 2'd1;
            end
        end
    end

endmodule

// File: rtl/hit_lane_merge.sv
// Merges three hit lanes into one circular FIFO and drains it one sample per cycle.
// Upstream is halted on the registered fill level; anything it pushes past a full FIFO is dropped C-first.
module hit_lane_merge
    import raster_sample_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int DEPTH_L2 = 3
)
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic signed [AXIS-1:0][SIGFIG-1:0] hit_R18S,
    input  logic [COLORS-1:0][SIGFIG-1:0]      color_R18U,
    input  logic                               hit_valid_R18H,
    input  logic signed [AXIS-1:0][SIGFIG-1:0] hit_R18S_B,
    input  logic [COLORS-1:0][SIGFIG-1:0]      color_R18U_B,
    input  logic                               hit_valid_R18H_B,
    input  logic signed [AXIS-1:0][SIGFIG-1:0] hit_R18S_C,
    input  logic [COLORS-1:0][SIGFIG-1:0]      color_R18U_C,
    input  logic                               hit_valid_R18H_C,
    output logic                               halt_RnnnnL,
    output logic signed [AXIS-1:0][SIGFIG-1:0] hit_R19S,
    output logic [COLORS-1:0][SIGFIG-1:0]      color_R19U,
    output logic                               hit_valid_R19H,
    input  logic                               ready_R19H,
    output logic [31:0]                        sample_cnt_RnnnnU,
    output logic                               overflow_R19H
);

    localparam int CW = DEPTH_L2 + 1;

    hit_sample_t          lane_a, lane_b, lane_c, head;
    hit_sample_t          slot [LANES];
    logic [LANES-1:0]     slot_valid;
    logic [1:0]           n_push, n_fit;
    hit_sample_t          mem [DEPTH];
    logic [DEPTH_L2-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]        count, space;
    logic                 pop, drop;

    assign lane_a = {hit_R18S,   color_R18U};
    assign lane_b = {hit_R18S_B, color_R18U_B};
    assign lane_c = {hit_R18S_C, color_R18U_C};

    hit_lane_compact u_compact (
        .lane_a     (lane_a),
        .lane_b     (lane_b),
        .lane_c     (lane_c),
        .lane_valid ({hit_valid_R18H_C, hit_valid_R18H_B, hit_valid_R18H}),
        .slot       (slot),
        .slot_valid (slot_valid),
        .n_push     (n_push)
    );

    // Space is judged on the registered count; a same-cycle pop does not make room.
    assign space = CW'(DEPTH) - count;
    assign drop  = CW'(n_push) > space;
    assign n_fit = drop ? space[1:0] : n_push;

    assign hit_valid_R19H = (count != '0);
    assign pop            = hit_valid_R19H & ready_R19H;
    assign halt_RnnnnL    = !(count > CW'(DEPTH - HALT_SLACK));

    // Storage is not reset, so the head is masked to zero while the FIFO is empty.
    assign head       = hit_valid_R19H ? mem[rd_ptr] : '0;
    assign hit_R19S   = head.pos;
    assign color_R19U = head.color;

    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (slot_valid[k] && (2'(k) < n_fit)) begin
                mem[wr_ptr + DEPTH_L2'(k)] <= slot[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            count             <= '0;
            sample_cnt_RnnnnU <= '0;
            overflow_R19H     <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + DEPTH_L2'(n_fit);
            rd_ptr <= rd_ptr + DEPTH_L2'(pop);
            count  <= count + CW'(n_fit) - CW'(pop);
            if (pop) begin
                sample_cnt_RnnnnU <= sample_cnt_RnnnnU + 32'd1;
            end
            if (drop) begin
                overflow_R19H <= 1'b1;
            end
        end
    end

endmodule
